// File: rtl/my_controller.sv
// my_controller: four-step (T0..T3) control FSM for a simple register-bus
// processor. It latches a 9-bit instruction {III,XXX,YYY} into IR in T0 and
// sequences the bus-source and register-load enables for mv, mvi, add and sub.
//
// Optional feature: define MY_CONTROLLER_MVNZ_EN to add opcode 100 (mvnz,
// move if G is nonzero). Without it, g_nz is ignored and 100 is a no-op.
//
// Handshake: run is a start request sampled only in T0 (it is not held or
// acknowledged). When AUTO_RUN=1, run is ignored and a fetch happens every T0.
// done is high for exactly the final step of each instruction. There is no
// back-pressure.
//
// fsm_state is a debug view of the state register (T0=0 .. T3=3).
module my_controller #(
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [8:0] instr,
  input  logic       g_nz,
  output logic [9:0] reg_enable_out,
  output logic [9:0] reg_enable_in,
  output logic       addsub,
  output logic       done,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef MY_CONTROLLER_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  state_t     state;
  state_t     next_state;
  logic [8:0] ir;
  logic       fetch;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

`ifndef MY_CONTROLLER_MVNZ_EN
  // g_nz has no consumer in this build.
  logic unused_g_nz;
  assign unused_g_nz = g_nz;
`endif

  assign opcode    = ir[8:6];
  assign rx        = ir[5:3];
  assign ry        = ir[2:0];
  assign fetch     = (state == T0) && (AUTO_RUN || run);
  assign fsm_state = state;

  // One-hot select of register R0..R7 on a 10-bit enable vector.
  function automatic logic [9:0] reg_sel(input logic [2:0] idx);
    logic [9:0] v;
    v = 10'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State register; reset drops back to T0 immediately, abandoning any instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= T0;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register; loaded only on a fetch so T1..T3 never see live instr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir <= 9'd0;
    end else if (fetch) begin
      ir <= instr;
    end
  end

  // Next-state and output decode from state and IR only.
  always_comb begin
    next_state     = state;
    reg_enable_out = 10'd0;
    reg_enable_in  = 10'd0;
    addsub         = 1'b0;
    done           = 1'b0;
    unique case (state)
      T0: begin
        if (fetch) next_state = T1;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            reg_enable_out = reg_sel(ry);
            reg_enable_in  = reg_sel(rx);
            done           = 1'b1;
            next_state     = T0;
          end
          OP_MVI: begin
            reg_enable_out = 10'h200;
            reg_enable_in  = reg_sel(rx);
            done           = 1'b1;
            next_state     = T0;
          end
          OP_ADD, OP_SUB: begin
            // A <- Rx
            reg_enable_out = reg_sel(rx);
            reg_enable_in  = 10'h200;
            next_state     = T2;
          end
`ifdef MY_CONTROLLER_MVNZ_EN
          OP_MVNZ: begin
            if (g_nz) begin
              reg_enable_out = reg_sel(ry);
              reg_enable_in  = reg_sel(rx);
            end
            done       = 1'b1;
            next_state = T0;
          end
`endif
          default: begin
            // Unsupported opcode: single-step no-op.
            done       = 1'b1;
            next_state = T0;
          end
        endcase
      end
      T2: begin
        // G <- A +/- Ry; opcode bit 0 distinguishes sub from add.
        reg_enable_out = reg_sel(ry);
        reg_enable_in  = 10'h100;
        addsub         = opcode[0];
        next_state     = T3;
      end
      T3: begin
        // Rx <- G
        reg_enable_out = 10'h100;
        reg_enable_in  = reg_sel(rx);
        done           = 1'b1;
        next_state     = T0;
      end
      default: next_state = T0;
    endcase
  end

endmodule

// File: doc/my_controller.md
MY_CONTROLLER -- requirements
Module: my_controller

Interface
REQ-001 Parameter AUTO_RUN, default 0: 0 = an instruction starts only when run=1 in T0; 1 = run is ignored and an instruction is fetched every T0.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 run  input  1  start request, sampled in T0 only.
REQ-005 instr  input  9  instruction word {III,XXX,YYY}: III = opcode, XXX = Rx index, YYY = Ry index.
REQ-006 g_nz  input  1  high when G register is nonzero; used only when MY_CONTROLLER_MVNZ_EN is defined.
REQ-007 reg_enable_out  output  10  bus-source select, one-hot or zero: bits 0-7 = R0-R7, bit 8 = G, bit 9 = external data.
REQ-008 reg_enable_in  output  10  register load enables, one-hot or zero: bits 0-7 = R0-R7, bit 8 = G, bit 9 = A.
REQ-009 addsub  output  1  ALU operation: 0 = add, 1 = subtract.
REQ-010 done  output  1  high during the final step of an instruction.

Function
REQ-011 FSM states are T0 (idle/fetch), T1, T2 and T3, held in a 2-bit state register.
REQ-012 In T0, when run=1 (or AUTO_RUN=1), the controller shall latch instr into a 9-bit IR and go to T1; otherwise it stays in T0.
REQ-013 In T0 all outputs shall be 0; run and instr are ignored in T1-T3.
REQ-014 Outputs shall be decoded combinationally from state and IR only, never from live instr.
REQ-015 mv (000), T1: out[Ry]=1, in[Rx]=1, done=1, next state T0.
REQ-016 mvi (001), T1: out[9]=1, in[Rx]=1, done=1, next state T0.
REQ-017 add (010) / sub (011), T1: out[Rx]=1, in[9]=1 (A<-Rx), next state T2.
REQ-018 add/sub, T2: out[Ry]=1, in[8]=1 (G<-A±Ry), addsub = opcode bit 0, next state T3.
REQ-019 add/sub, T3: out[8]=1, in[Rx]=1, done=1, next state T0.
REQ-020 Latency from run sampled in T0: mv/mvi done in the 1st following cycle; add/sub done in the 3rd following cycle.
REQ-021 In every state, at most one bit of reg_enable_out and at most one bit of reg_enable_in shall be high.
REQ-022 addsub shall be 0 in every state other than T2 of sub.
REQ-023 An opcode not enabled by the configuration is a no-op: T1 has all enables 0, done=1, next state T0.
REQ-024 Rx==Ry is legal and needs no special handling: mv R3,R3 drives out[3] and in[3] in the same cycle.

Reset
REQ-025 rst=0 shall force state T0 and IR to 0 immediately, without waiting for a clock edge.
REQ-026 While rst=0, all outputs shall be 0.
REQ-027 Reset asserted mid-instruction abandons the instruction; no further enables are issued for it.
REQ-028 After rst returns to 1, the first fetch occurs on the first rising edge with run=1 in T0.

Configuration
REQ-029 Macro MY_CONTROLLER_MVNZ_EN, when defined, adds opcode 100 (mvnz), executed in T1: if g_nz=1 then out[Ry]=1 and in[Rx]=1, else no enables; done=1 and next state T0 in both cases.
REQ-030 When MY_CONTROLLER_MVNZ_EN is undefined, g_nz is ignored and opcode 100 is a no-op per REQ-023.
REQ-031 Opcodes 101-111 are no-ops in both builds.

Verification
REQ-032 Reset then instr=001_010_000, run=1 one cycle -> next cycle out=10'h200, in=10'h004, done=1; following cycle all outputs 0.
REQ-033 instr=000_001_110 (mv R1,R6) -> T1: out=10'h040, in=10'h002, done=1.
REQ-034 instr=011_000_001 (sub R0,R1) -> T1: out=10'h001, in=10'h200; T2: out=10'h002, in=10'h100, addsub=1; T3: out=10'h100, in=10'h001, done=1.
REQ-035 Start add, drop rst to 0 mid-T2 between clock edges -> outputs go to 0 at once; after release, the controller waits in T0 until run=1.
REQ-036 instr=100_011_101 with g_nz=0, then again with g_nz=1 -> with macro: no enables then out=10'h020, in=10'h008, done=1 in both cases; without macro: both are no-ops with done=1.
REQ-037 Change instr to 010_111_111 while a sub is in T2 -> T2/T3 outputs unchanged (IR holds the original sub).
